// File: rtl/bg_scroll_pkg.sv
// Shared definitions for the background scroller: FSM states, speed codes
// and the speed-code-to-row-step mapping.
package bg_scroll_pkg;

  typedef enum logic [1:0] {
    S_DRAW = 2'd0,
    S_LAST = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SPEED_0 = 2'b00;
  localparam logic [1:0] SPEED_1 = 2'b01;
  localparam logic [1:0] SPEED_2 = 2'b10;
  localparam logic [1:0] SPEED_4 = 2'b11;

  function automatic logic [2:0] speed_step(input logic [1:0] speed);
    case (speed)
      SPEED_1: speed_step = 3'd1;
      SPEED_2: speed_step = 3'd2;
      SPEED_4: speed_step = 3'd4;
      default: speed_step = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/scroll_offset.sv
// Vertical scroll offset register, wrapped into 0..HEIGHT-1.
// Updates only on the load cycle; no backpressure.
module scroll_offset
  import bg_scroll_pkg::*;
#(
  parameter int HEIGHT = 120,
  parameter int YW     = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic          en,
  input  logic [1:0]    speed,
  input  logic          dir,
  output logic [YW-1:0] offset
);

  localparam logic [YW:0] H_EXT = (YW+1)'(HEIGHT);

  logic [YW:0] cur;
  logic [YW:0] step;
  logic [YW:0] inc;
  logic [YW:0] dec;
  logic [YW:0] nxt;

  assign cur  = {1'b0, offset};
  assign step = (YW+1)'(speed_step(speed));
  // HEIGHT > 4 guarantees one conditional correction is always enough
  assign inc  = cur + step;
  assign dec  = (cur < step) ? (cur + H_EXT - step) : (cur - step);
  assign nxt  = dir ? dec : ((inc >= H_EXT) ? (inc - H_EXT) : inc);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      offset <= '0;
    end else if (load && en && (speed != SPEED_0)) begin
      offset <= YW'(nxt);
    end
  end

endmodule

// File: rtl/bg_scroller.sv
// Scans a WIDTH x HEIGHT background row by row, reading memory at a scrolled row.
// x/y/plot lag mem_addr by one cycle to line up with mem_data; no backpressure.
module bg_scroller
  import bg_scroll_pkg::*;
#(
  parameter int WIDTH     = 160,
  parameter int HEIGHT    = 120,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int COLOUR_W  = 3,
  parameter int ADDR_W    = 15,
  parameter int FRAME_GAP = 1000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                en,
  input  logic [1:0]          speed,
  input  logic                dir,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [COLOUR_W-1:0] mem_data,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                frame_done,
  output logic [YW-1:0]       offset
);

  localparam int          GW     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(FRAME_GAP - 1);
  localparam logic [YW:0]   H_EXT  = (YW+1)'(HEIGHT);

  state_t        state, state_nx;
  logic [XW-1:0] xc, xc_nx;
  logic [YW-1:0] yc, yc_nx;
  logic [GW-1:0] gc, gc_nx;
  logic [YW:0]   sr_sum;
  logic [YW-1:0] sr;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_DRAW;
      xc    <= '0;
      yc    <= '0;
      gc    <= '0;
    end else begin
      state <= state_nx;
      xc    <= xc_nx;
      yc    <= yc_nx;
      gc    <= gc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    xc_nx    = xc;
    yc_nx    = yc;
    gc_nx    = '0;
    unique case (state)
      S_DRAW: begin
        if (xc == X_LAST) begin
          xc_nx = '0;
          if (yc == Y_LAST) begin
            yc_nx    = '0;
            state_nx = S_LAST;
          end else begin
            yc_nx = yc + 1'b1;
          end
        end else begin
          xc_nx = xc + 1'b1;
        end
      end
      S_LAST: state_nx = S_GAP;
      S_GAP: begin
        if (gc == G_LAST) begin
          state_nx = S_DRAW;
        end else begin
          gc_nx = gc + 1'b1;
        end
      end
      default: state_nx = S_DRAW;
    endcase
  end

  // yc and offset are both below HEIGHT, so a single subtract wraps the row
  assign sr_sum   = {1'b0, yc} + {1'b0, offset};
  assign sr       = YW'((sr_sum >= H_EXT) ? (sr_sum - H_EXT) : sr_sum);
  assign mem_addr = ADDR_W'(sr) * ADDR_W'(WIDTH) + ADDR_W'(xc);
  assign colour   = mem_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      x          <= '0;
      y          <= '0;
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      x          <= xc;
      y          <= yc;
      plot       <= (state == S_DRAW);
      frame_done <= (state == S_LAST);
    end
  end

  scroll_offset #(
    .HEIGHT(HEIGHT),
    .YW    (YW)
  ) u_scroll_offset (
    .Clock (Clock),
    .Reset (Reset),
    .load  (state == S_LAST),
    .en    (en),
    .speed (speed),
    .dir   (dir),
    .offset(offset)
  );

endmodule

// File: tb/tb_bg_scroller.sv
// Bench for bg_scroller: small 4x6 instance against a modulo-arithmetic scroll model,
// plus a default-size instance for frame timing.
module tb_bg_scroller;

  localparam int W = 4, H = 6, GAP = 2, XW = 3, YW = 3, CW = 3, AW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          en, dir;
  logic [1:0]    speed;
  logic [AW-1:0] mem_addr, cap_addr;
  logic [CW-1:0] mem_data, colour;
  logic [XW-1:0] x;
  logic [YW-1:0] y, offset;
  logic          plot, frame_done;
  logic [CW-1:0] mem [32];

  logic          rst_big;
  logic [14:0]   b_addr;
  logic [7:0]    b_x;
  logic [6:0]    b_y, b_off;
  logic [2:0]    b_colour;
  logic          b_plot, b_fd;

  int total = 0;
  int passed = 0;
  int m_off = 0;
  int n;

  always #5 Clock = ~Clock;

  bg_scroller #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .COLOUR_W(CW), .ADDR_W(AW), .FRAME_GAP(GAP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .en(en), .speed(speed), .dir(dir),
    .mem_addr(mem_addr), .mem_data(mem_data), .x(x), .y(y), .colour(colour),
    .plot(plot), .frame_done(frame_done), .offset(offset)
  );

  bg_scroller u_big (
    .Clock(Clock), .Reset(rst_big), .en(1'b1), .speed(2'b01), .dir(1'b0),
    .mem_addr(b_addr), .mem_data(3'd0), .x(b_x), .y(b_y), .colour(b_colour),
    .plot(b_plot), .frame_done(b_fd), .offset(b_off)
  );

  // Synchronous-read memory: data valid one cycle after the address
  always @(posedge Clock) begin
    mem_data <= mem[mem_addr];
    cap_addr <= mem_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int src_addr(input int i, input int off);
    return ((i / W + off) % H) * W + (i % W);
  endfunction

  task automatic check_pixel(input int i);
    chk("plot", plot, 1);
    chk("x", x, i % W);
    chk("y", y, i / W);
    chk("addr", cap_addr, src_addr(i, m_off));
    chk("colour", colour, mem[src_addr(i, m_off)]);
    chk("offset_hold", offset, m_off);
    chk("fd_low", frame_done, 0);
  endtask

  // One full frame starting at the next negedge; boundary inputs are driven
  // during the last plot cycle so the S_LAST->S_GAP edge samples them.
  task automatic do_frame(input logic b_en, input logic [1:0] b_speed, input logic b_dir,
                          input bit scramble);
    int step;
    for (int i = 0; i < W * H; i++) begin
      @(negedge Clock);
      check_pixel(i);
      if (i == W * H - 1) begin
        en = b_en; speed = b_speed; dir = b_dir;
      end else if (scramble) begin
        en = 1'($urandom); speed = 2'($urandom); dir = 1'($urandom);
      end
    end
    step = (b_speed == 2'b11) ? 4 : int'(b_speed);
    if (b_en) m_off = b_dir ? (m_off - step + H) % H : (m_off + step) % H;
    @(negedge Clock);
    chk("fd_pulse", frame_done, 1);
    chk("plot_after", plot, 0);
    chk("offset_new", offset, m_off);
    if (scramble) begin
      en = 1'($urandom); speed = 2'($urandom); dir = 1'($urandom);
    end
    for (int g = 0; g < GAP; g++) begin
      @(negedge Clock);
      chk("gap_plot", plot, 0);
      chk("gap_fd", frame_done, 0);
      chk("gap_offset", offset, m_off);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 3'($urandom);
    Reset = 1'b1; rst_big = 1'b1;
    en = 1'b1; speed = 2'b00; dir = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_plot", plot, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_offset", offset, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    Reset = 1'b0;

    do_frame(1'b1, 2'b00, 1'b0, 1'b0);
    chk("speed0_offset", offset, 0);
    do_frame(1'b1, 2'b01, 1'b0, 1'b0);
    chk("inc1_offset", offset, 1);
    do_frame(1'b1, 2'b10, 1'b1, 1'b0);
    chk("dec2_offset", offset, 5);
    do_frame(1'b1, 2'b11, 1'b0, 1'b0);
    chk("inc4_offset", offset, 3);
    do_frame(1'b0, 2'b11, 1'b1, 1'b1);
    chk("en0_offset", offset, 3);

    for (int f = 0; f < 10; f++)
      do_frame(1'($urandom), 2'($urandom), 1'($urandom), 1'b1);

    for (int f = 0; f < H; f++) do_frame(1'b1, 2'b01, 1'b0, 1'b1);
    if (m_off == 0) do_frame(1'b1, 2'b01, 1'b0, 1'b0);

    // Abandon a frame while pixel (2,1) is on the output
    for (int i = 0; i <= W + 2; i++) begin
      @(negedge Clock);
      check_pixel(i);
    end
    Reset = 1'b1;
    #1;
    chk("midrst_plot", plot, 0);
    chk("midrst_offset", offset, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_fd", frame_done, 0);
    @(negedge Clock);
    Reset = 1'b0;
    m_off = 0;
    do_frame(1'b1, 2'b01, 1'b1, 1'b1);
    do_frame(1'b1, 2'b10, 1'b0, 1'b1);

    // Default-size instance: first frame_done after WIDTH*HEIGHT+1 cycles,
    // then one every WIDTH*HEIGHT+1+FRAME_GAP cycles
    @(negedge Clock);
    rst_big = 1'b0;
    n = 0;
    while (b_fd !== 1'b1 && n < 25000) begin
      @(negedge Clock);
      n++;
    end
    chk("big_first_fd", n, 19201);
    chk("big_offset1", b_off, 1);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (b_fd !== 1'b1 && n < 25000);
    chk("big_period", n, 20201);
    chk("big_offset2", b_off, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
